// File: rtl/mmio_peripheral_responder.sv
// mmio_peripheral_responder
// Memory-mapped responder on the multicycle controller's memory path. It decodes
// a small register window and returns read data one cycle after the read strobe,
// which lines up with the MEMREAD->MEMWB spacing. The window holds a GPIO output
// register, a synchronized GPIO input with rising-edge capture, and a prescaled
// down-counting timer that can raise an interrupt.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   addr       byte address from the datapath address mux
//   wdata      write data
//   mem_read   one-cycle read strobe
//   mem_write  write strobe
//   sel        combinational: address inside the window and word aligned
//   rdata      registered read data, held until the next read strobe
//   gpio_in    asynchronous external inputs
//   gpio_out   GPIO output register
//   irq        registered timer interrupt

module mmio_peripheral_responder #(
   parameter logic [31:0] BASE_ADDR = 32'h1001_0000,
   parameter int unsigned GPIO_W    = 8,
   parameter int unsigned PRESCALE  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [31:0]       addr,
   input  logic [31:0]       wdata,
   input  logic              mem_read,
   input  logic              mem_write,
   output logic              sel,
   output logic [31:0]       rdata,
   input  logic [GPIO_W-1:0] gpio_in,
   output logic [GPIO_W-1:0] gpio_out,
   output logic              irq
);

   localparam int unsigned DATA_W    = 32;
   localparam int unsigned IDX_W     = 3;
   localparam int unsigned PS_W      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [31:0] WIN_LAST  = 32'h0000_001C;
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

   localparam logic [IDX_W-1:0] REG_GPIO_OUT  = 3'd0;
   localparam logic [IDX_W-1:0] REG_GPIO_IN   = 3'd1;
   localparam logic [IDX_W-1:0] REG_GPIO_EDGE = 3'd2;
   localparam logic [IDX_W-1:0] REG_CTRL      = 3'd3;
   localparam logic [IDX_W-1:0] REG_LOAD      = 3'd4;
   localparam logic [IDX_W-1:0] REG_COUNT     = 3'd5;
   localparam logic [IDX_W-1:0] REG_STATUS    = 3'd6;

   typedef struct packed {
      logic irq_en;
      logic auto_rl;
      logic en;
   } ctrl_t;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } tmr_state_t;

   logic [DATA_W-1:0] off;
   logic [IDX_W-1:0]  idx;
   logic              wr_en;
   logic              wr_gpio_out, wr_edge, wr_ctrl, wr_load, wr_status;
   logic [DATA_W-1:0] rd_mux;

   logic [GPIO_W-1:0] s1, s2, s3;
   logic [GPIO_W-1:0] gpio_edge;

   tmr_state_t        state;
   ctrl_t             ctrl;
   logic [DATA_W-1:0] load;
   logic [DATA_W-1:0] count;
   logic [PS_W-1:0]   presc;
   logic              exp_flag;
   logic              stop_req;
   logic              tick;
   logic              expire;

   // Address decode: unsigned offset wraps for addresses below the base.
   always_comb begin
      off = addr - BASE_ADDR;
      sel = (off <= WIN_LAST) && (addr[1:0] == 2'b00);
      idx = off[4:2];
   end

   always_comb begin
      wr_en       = mem_write & sel;
      wr_gpio_out = wr_en && (idx == REG_GPIO_OUT);
      wr_edge     = wr_en && (idx == REG_GPIO_EDGE);
      wr_ctrl     = wr_en && (idx == REG_CTRL);
      wr_load     = wr_en && (idx == REG_LOAD);
      wr_status   = wr_en && (idx == REG_STATUS);
   end

   // Read mux sees pre-write register values, so read+write returns old data.
   always_comb begin
      rd_mux = '0;
      case (idx)
         REG_GPIO_OUT:  rd_mux = DATA_W'(gpio_out);
         REG_GPIO_IN:   rd_mux = DATA_W'(s2);
         REG_GPIO_EDGE: rd_mux = DATA_W'(gpio_edge);
         REG_CTRL:      rd_mux = DATA_W'(ctrl);
         REG_LOAD:      rd_mux = load;
         REG_COUNT:     rd_mux = count;
         REG_STATUS:    rd_mux = DATA_W'(exp_flag);
         default:       rd_mux = '0;
      endcase
   end

   // Read data register: updates only on a strobe, zero for unselected addresses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata <= '0;
      end else if (mem_read) begin
         rdata <= sel ? rd_mux : '0;
      end
   end

   // GPIO output and timer reload registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gpio_out <= '0;
         load     <= '0;
      end else begin
         if (wr_gpio_out) gpio_out <= wdata[GPIO_W-1:0];
         if (wr_load)     load     <= wdata;
      end
   end

   // Input synchronizer plus a third flop for rising-edge detection; set beats W1C.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1        <= '0;
         s2        <= '0;
         s3        <= '0;
         gpio_edge <= '0;
      end else begin
         s1        <= gpio_in;
         s2        <= s1;
         s3        <= s2;
         gpio_edge <= (gpio_edge & ~(wr_edge ? wdata[GPIO_W-1:0] : '0)) | (s2 & ~s3);
      end
   end

   // Tick/expiry qualifiers; a CTRL write with EN=0 suppresses the tick in that cycle.
   always_comb begin
      stop_req = wr_ctrl && !wdata[0];
      tick     = (state == RUN) && !stop_req && (presc == PS_LAST);
      expire   = tick && (count == '0);
   end

   // Timer FSM with its control, count, prescaler and expiry flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         ctrl     <= '0;
         count    <= '0;
         presc    <= '0;
         exp_flag <= 1'b0;
      end else begin
         exp_flag <= (exp_flag & ~(wr_status & wdata[0])) | expire;
         if (wr_ctrl) ctrl <= ctrl_t'(wdata[2:0]);
         case (state)
            IDLE: begin
               if (wr_ctrl && wdata[0]) begin
                  state <= RUN;
                  count <= load;
                  presc <= '0;
               end
            end
            RUN: begin
               if (stop_req) begin
                  state <= IDLE;
               end else begin
                  presc <= tick ? '0 : presc + PS_W'(1);
                  if (tick) begin
                     if (count != '0) begin
                        count <= count - DATA_W'(1);
                     end else if (ctrl.auto_rl) begin
                        count <= load;
                     end else if (!wr_ctrl) begin
                        // One-shot: stop and drop EN unless software rewrote CTRL now.
                        state   <= IDLE;
                        ctrl.en <= 1'b0;
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Interrupt trails the expiry flag by one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq <= 1'b0;
      end else begin
         irq <= exp_flag & ctrl.irq_en;
      end
   end

endmodule

// File: tb/tb_mmio_peripheral_responder.sv
// Scoreboard bench for mmio_peripheral_responder: reads push their expected data,
// a negedge monitor pops and compares when read data becomes valid.

module tb_mmio_peripheral_responder;

   localparam logic [31:0] BASE = 32'h1001_0000;
   localparam int unsigned GW   = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [31:0]   addr;
   logic [31:0]   wdata;
   logic          mem_read;
   logic          mem_write;
   logic          sel;
   logic [31:0]   rdata;
   logic [GW-1:0] gpio_in;
   logic [GW-1:0] gpio_out;
   logic          irq;

   int vectors     = 0;
   int miscompares = 0;

   logic [31:0] exp_q[$];
   string       name_q[$];
   logic        rd_pend;

   mmio_peripheral_responder #(
      .BASE_ADDR(BASE),
      .GPIO_W   (GW),
      .PRESCALE (4)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .addr     (addr),
      .wdata    (wdata),
      .mem_read (mem_read),
      .mem_write(mem_write),
      .sel      (sel),
      .rdata    (rdata),
      .gpio_in  (gpio_in),
      .gpio_out (gpio_out),
      .irq      (irq)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      vectors++;
      if (act !== expv) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
      end
   endtask

   // A read strobe sampled at a posedge means rdata is valid for the following cycle.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd_pend <= 1'b0;
      else        rd_pend <= mem_read;
   end

   always @(negedge clk) begin
      if (rst_n && rd_pend) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected read: got 0x%08h expected no read", rdata);
         end else begin
            logic [31:0] e;
            string       n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            chk(n, rdata, e);
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      addr = a; wdata = d; mem_write = 1'b1;
      @(posedge clk); #1;
      mem_write = 1'b0;
   endtask

   task automatic bus_read(input logic [31:0] a, input logic [31:0] expv, input string name);
      addr = a; mem_read = 1'b1;
      exp_q.push_back(expv);
      name_q.push_back(name);
      @(posedge clk); #1;
      mem_read = 1'b0;
   endtask

   task automatic bus_rw(input logic [31:0] a, input logic [31:0] d, input logic [31:0] expv,
                         input string name);
      addr = a; wdata = d; mem_read = 1'b1; mem_write = 1'b1;
      exp_q.push_back(expv);
      name_q.push_back(name);
      @(posedge clk); #1;
      mem_read = 1'b0; mem_write = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; addr = '0; wdata = '0; mem_read = 1'b0; mem_write = 1'b0; gpio_in = '0;
      repeat (3) @(posedge clk); #1;
      chk("reset gpio_out", 32'(gpio_out), 32'h0);
      chk("reset irq", 32'(irq), 32'h0);
      chk("reset rdata", rdata, 32'h0);
      rst_n = 1'b1;
      idle(1);

      // Every register reads zero after reset, including the reserved slot.
      for (int i = 0; i < 8; i++)
         bus_read(BASE + 32'(4 * i), 32'h0, $sformatf("reset read off 0x%02h", 4 * i));

      // GPIO_OUT write, readback, misaligned and out-of-window accesses.
      bus_write(BASE, 32'h0000_00A5);
      chk("gpio_out after write", 32'(gpio_out), 32'hA5);
      bus_read(BASE, 32'h0000_00A5, "gpio_out readback");
      addr = BASE + 32'h1; wdata = 32'h5A; mem_write = 1'b1;
      #1;
      chk("sel misaligned", 32'(sel), 32'h0);
      @(posedge clk); #1;
      mem_write = 1'b0;
      chk("gpio_out after misaligned write", 32'(gpio_out), 32'hA5);
      addr = BASE + 32'h20; #1;
      chk("sel above window", 32'(sel), 32'h0);
      addr = BASE - 32'h4; #1;
      chk("sel below window", 32'(sel), 32'h0);
      addr = BASE + 32'h1C; #1;
      chk("sel last word", 32'(sel), 32'h1);
      bus_read(BASE + 32'h20, 32'h0, "out-of-window read");
      bus_read(BASE, 32'h0000_00A5, "gpio_out readback 2");
      bus_read(BASE + 32'h2, 32'h0, "misaligned read");
      bus_rw(BASE, 32'h3C, 32'h0000_00A5, "read+write returns old");
      chk("gpio_out after read+write", 32'(gpio_out), 32'h3C);
      bus_write(BASE + 32'h1C, 32'hFFFF_FFFF);
      bus_read(BASE + 32'h1C, 32'h0, "reserved reads zero");

      // GPIO input synchronizer and rising-edge capture.
      gpio_in = 8'h81;
      idle(1);
      bus_read(BASE + 32'h04, 32'h0, "gpio_in not yet through sync");
      bus_read(BASE + 32'h04, 32'h81, "gpio_in synced");
      bus_read(BASE + 32'h08, 32'h81, "edge captured");
      bus_write(BASE + 32'h08, 32'h1);
      bus_read(BASE + 32'h08, 32'h80, "edge after w1c bit0");
      gpio_in = 8'h80;
      idle(4);
      bus_read(BASE + 32'h08, 32'h80, "falling edge ignored");
      gpio_in = 8'h81;
      idle(2);
      bus_write(BASE + 32'h08, 32'h1);
      bus_read(BASE + 32'h08, 32'h81, "edge set beats w1c");

      // One-shot timer: LOAD=3, EN|IRQ_EN, expiry 16 cycles after the CTRL write.
      bus_write(BASE + 32'h10, 32'd3);
      bus_write(BASE + 32'h0C, 32'h5);
      idle(4);
      bus_read(BASE + 32'h14, 32'd2, "count after first tick");
      idle(10);
      chk("irq low before expiry", 32'(irq), 32'h0);
      idle(1);
      chk("irq low on expiry cycle", 32'(irq), 32'h0);
      idle(1);
      chk("irq one cycle after expiry", 32'(irq), 32'h1);
      bus_read(BASE + 32'h0C, 32'h4, "ctrl EN cleared");
      bus_read(BASE + 32'h14, 32'h0, "count zero after one-shot");
      bus_read(BASE + 32'h18, 32'h1, "status EXP set");
      bus_write(BASE + 32'h18, 32'h1);
      chk("irq still high at clear", 32'(irq), 32'h1);
      idle(1);
      chk("irq drops after clear", 32'(irq), 32'h0);

      // Auto-reload: LOAD=1 gives 8-cycle periods; LOAD=5 mid-run applies next period.
      bus_write(BASE + 32'h10, 32'd1);
      bus_write(BASE + 32'h0C, 32'h7);
      idle(7);
      chk("auto irq low before first expiry", 32'(irq), 32'h0);
      idle(1);
      chk("auto irq low on expiry cycle", 32'(irq), 32'h0);
      idle(1);
      chk("auto irq after first expiry", 32'(irq), 32'h1);
      bus_write(BASE + 32'h10, 32'd5);
      bus_write(BASE + 32'h18, 32'h1);
      idle(4);
      chk("auto irq low mid-period", 32'(irq), 32'h0);
      idle(1);
      chk("auto irq low on second expiry cycle", 32'(irq), 32'h0);
      idle(1);
      chk("auto second period unchanged", 32'(irq), 32'h1);
      bus_write(BASE + 32'h18, 32'h1);
      bus_read(BASE + 32'h14, 32'd5, "count reloaded with new LOAD");
      idle(20);
      chk("auto irq low during long period", 32'(irq), 32'h0);
      idle(1);
      chk("auto irq low on third expiry cycle", 32'(irq), 32'h0);
      idle(1);
      chk("auto third period uses LOAD=5", 32'(irq), 32'h1);

      // Reset in the middle of a running count.
      bus_write(BASE + 32'h0C, 32'h0);
      bus_write(BASE + 32'h10, 32'd3);
      bus_write(BASE + 32'h0C, 32'h5);
      idle(3);
      bus_read(BASE + 32'h10, 32'd3, "load before reset");
      chk("irq before reset", 32'(irq), 32'h1);
      @(negedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("rdata cleared by reset", rdata, 32'h0);
      chk("irq cleared by reset", 32'(irq), 32'h0);
      chk("gpio_out cleared by reset", 32'(gpio_out), 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle(30);
      chk("no expiry after reset", 32'(irq), 32'h0);
      bus_read(BASE + 32'h14, 32'h0, "count after reset");
      bus_read(BASE + 32'h0C, 32'h0, "ctrl after reset");
      bus_read(BASE + 32'h18, 32'h0, "status after reset");
      bus_read(BASE + 32'h10, 32'h0, "load after reset");
      idle(2);
      chk("scoreboard drained", 32'(exp_q.size()), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
